// File: rtl/circuito_jogo_param_pkg.sv
// circuito_jogo_param_pkg: state codes and width helper shared by the memory game.
package circuito_jogo_param_pkg;
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    ESPERA_JOGADA  = 4'h2,
    REGISTRA       = 4'h3,
    COMPARA        = 4'h4,
    PROXIMA_JOGADA = 4'h5,
    PROXIMA_RODADA = 4'h6,
    FIM_ACERTOU    = 4'hA,
    FIM_ERROU      = 4'hE,
    FIM_TIMEOUT    = 4'hD
  } estado_t;
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/rom_jogadas_param.sv
// rom_jogadas_param: fixed play sequence, address a holds one-hot bit (a mod N_CHAVES).
module rom_jogadas_param
  import circuito_jogo_param_pkg::*;
#(
  parameter int N_CHAVES  = 4,
  parameter int N_JOGADAS = 16
) (
  input  logic [clog2w(N_JOGADAS)-1:0] endereco,
  output logic [N_CHAVES-1:0]          dado
);
  assign dado = N_CHAVES'(1) << (endereco % N_CHAVES);
endmodule

// File: rtl/circuito_jogo_param.sv
// circuito_jogo_param: sequence-memory game FSM with per-play timeout and debug taps.
module circuito_jogo_param
  import circuito_jogo_param_pkg::*;
#(
  parameter int N_CHAVES       = 4,
  parameter int N_JOGADAS      = 16,
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_CHAVES-1:0] chaves,
  output logic [N_CHAVES-1:0] leds,
  output logic                ganhou,
  output logic                perdeu,
  output logic                pronto,
  output logic [3:0]          db_estado,
  output logic [3:0]          db_rodada,
  output logic [3:0]          db_contagem,
  output logic [N_CHAVES-1:0] db_memoria,
  output logic                db_igual,
  output logic                db_timeout,
  output logic                db_tem_jogada
);
  localparam int W  = clog2w(N_JOGADAS);
  localparam int TW = clog2w(TIMEOUT_CICLOS);
  estado_t             estado_q, estado_d;
  logic [W-1:0]        rodada_q, rodada_d, contagem_q, contagem_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [N_CHAVES-1:0] jogada_q, jogada_d, memoria;
  logic                hist_q, jogada_feita, timeout, igual;

  rom_jogadas_param #(.N_CHAVES(N_CHAVES), .N_JOGADAS(N_JOGADAS)) u_rom (
    .endereco(contagem_q),
    .dado    (memoria)
  );

  // a play is the idle-to-pressed transition, so held keys count once
  assign jogada_feita = (|chaves) & ~hist_q;
  assign timeout      = (estado_q == ESPERA_JOGADA) && (tmr_q == TW'(TIMEOUT_CICLOS - 1));
  assign igual        = jogada_q == memoria;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      estado_q   <= INICIAL;
      rodada_q   <= '0;
      contagem_q <= '0;
      tmr_q      <= '0;
      jogada_q   <= '0;
      hist_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      rodada_q   <= rodada_d;
      contagem_q <= contagem_d;
      tmr_q      <= tmr_d;
      jogada_q   <= jogada_d;
      hist_q     <= |chaves;
    end

  always_comb begin
    estado_d   = estado_q;
    rodada_d   = rodada_q;
    contagem_d = contagem_q;
    jogada_d   = jogada_q;
    tmr_d      = (estado_q == ESPERA_JOGADA) ? tmr_q + 1'b1 : '0;
    case (estado_q)
      INICIAL:        if (iniciar) estado_d = PREPARACAO;
      PREPARACAO: begin
        rodada_d   = '0;
        contagem_d = '0;
        jogada_d   = '0;
        estado_d   = ESPERA_JOGADA;
      end
      ESPERA_JOGADA:  estado_d = jogada_feita ? REGISTRA : timeout ? FIM_TIMEOUT : ESPERA_JOGADA;
      REGISTRA: begin
        jogada_d = chaves;
        estado_d = COMPARA;
      end
      COMPARA:        estado_d = !igual ? FIM_ERROU
                               : (contagem_q < rodada_q) ? PROXIMA_JOGADA
                               : (rodada_q == W'(N_JOGADAS - 1)) ? FIM_ACERTOU : PROXIMA_RODADA;
      PROXIMA_JOGADA: begin
        contagem_d = contagem_q + 1'b1;
        estado_d   = ESPERA_JOGADA;
      end
      PROXIMA_RODADA: begin
        rodada_d   = rodada_q + 1'b1;
        contagem_d = '0;
        estado_d   = ESPERA_JOGADA;
      end
      default:        if (iniciar) estado_d = PREPARACAO;
    endcase
  end

  assign leds          = jogada_q;
  assign ganhou        = estado_q == FIM_ACERTOU;
  assign perdeu        = (estado_q == FIM_ERROU) || (estado_q == FIM_TIMEOUT);
  assign pronto        = ganhou | perdeu;
  assign db_estado     = estado_q;
  assign db_rodada     = 4'(rodada_q);
  assign db_contagem   = 4'(contagem_q);
  assign db_memoria    = memoria;
  assign db_igual      = igual;
  assign db_timeout    = estado_q == FIM_TIMEOUT;
  assign db_tem_jogada = jogada_feita;
endmodule

// File: tb/tb_circuito_jogo_param.sv
// tb_circuito_jogo_param: scenario tasks plus a compara-state scoreboard on the play register.
module tb_circuito_jogo_param;
  logic       clock = 1'b0, reset = 1'b0, iniciar = 1'b0;
  logic [3:0] chaves = 4'b0;
  logic [3:0] leds, db_estado, db_rodada, db_contagem, db_memoria;
  logic       ganhou, perdeu, pronto, db_igual, db_timeout, db_tem_jogada;
  int         vectors = 0, miscompares = 0;
  logic [4:0] sb[$];

  circuito_jogo_param #(.N_CHAVES(4), .N_JOGADAS(4), .TIMEOUT_CICLOS(100)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves), .leds(leds),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .db_estado(db_estado),
    .db_rodada(db_rodada), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_igual(db_igual), .db_timeout(db_timeout), .db_tem_jogada(db_tem_jogada)
  );

  always #5 clock = ~clock;

  // every visit to compara must match the oldest expected {leds, db_igual}
  always @(negedge clock)
    if (reset && db_estado == 4'h4) begin
      logic [4:0] e;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: got %b with no expected entry", {leds, db_igual});
      end else begin
        e = sb.pop_front();
        if ({leds, db_igual} !== e) begin
          miscompares++;
          $display("FAIL sb_compara: got leds=%b igual=%b expected leds=%b igual=%b", leds, db_igual, e[4:1], e[0]);
        end
      end
    end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic press(input logic [3:0] k, input int c);
    sb.push_back({k, k == 4'(1 << (c % 4))});
    chaves = k;
    repeat (4) @(negedge clock);
    chaves = 4'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic start();
    int n = 0;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    while (db_estado !== 4'h2 && n < 10) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (db_estado !== 4'h2) begin miscompares++; $display("FAIL start_espera: got %h expected 2", db_estado); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    vectors++;
    if ({db_estado, leds, ganhou, perdeu, pronto, db_igual, db_timeout} !== 13'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got estado=%h leds=%b g=%b p=%b r=%b i=%b t=%b expected all 0",
               db_estado, leds, ganhou, perdeu, pronto, db_igual, db_timeout);
    end
    vectors++;
    if ({db_rodada, db_contagem} !== 8'h00) begin miscompares++; $display("FAIL reset_counters: got %h%h expected 00", db_rodada, db_contagem); end
    reset = 1'b1;
    repeat (5) @(negedge clock);
    vectors++;
    if (db_estado !== 4'h0) begin miscompares++; $display("FAIL idle_without_iniciar: got %h expected 0", db_estado); end
  endtask

  task automatic test_win();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    vectors++;
    if (db_estado !== 4'h1) begin miscompares++; $display("FAIL preparacao: got %h expected 1", db_estado); end
    @(negedge clock);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c <= r; c++) press(4'(1 << c), c);
    vectors++;
    if ({ganhou, perdeu, pronto, db_estado, db_rodada} !== {3'b101, 4'hA, 4'h3}) begin
      miscompares++;
      $display("FAIL win: got g=%b p=%b r=%b estado=%h rodada=%h expected 1 0 1 A 3", ganhou, perdeu, pronto, db_estado, db_rodada);
    end
    repeat (10) @(negedge clock);
    vectors++;
    if (db_estado !== 4'hA) begin miscompares++; $display("FAIL win_hold: got %h expected A", db_estado); end
  endtask

  task automatic test_error();
    start();
    vectors++;
    if (db_rodada !== 4'h0) begin miscompares++; $display("FAIL restart_from_win: got rodada %h expected 0", db_rodada); end
    press(4'b0001, 0);
    press(4'b0001, 0);
    press(4'b0100, 1);
    vectors++;
    if ({ganhou, perdeu, pronto, db_estado, leds, db_igual, db_timeout} !== {3'b011, 4'hE, 4'b0100, 2'b00}) begin
      miscompares++;
      $display("FAIL error: got g=%b p=%b r=%b estado=%h leds=%b igual=%b t=%b expected 0 1 1 E 0100 0 0",
               ganhou, perdeu, pronto, db_estado, leds, db_igual, db_timeout);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    start();
    vectors++;
    if ({db_rodada, db_contagem, leds} !== 12'h000) begin
      miscompares++;
      $display("FAIL restart_from_error: got rodada=%h contagem=%h leds=%b expected 0 0 0000", db_rodada, db_contagem, leds);
    end
    while (db_estado === 4'h2 && n < 300) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (n !== 100) begin miscompares++; $display("FAIL timeout_cycles: got %0d expected 100", n); end
    vectors++;
    if ({db_estado, perdeu, db_timeout, pronto, ganhou} !== {4'hD, 4'b1110}) begin
      miscompares++;
      $display("FAIL timeout: got estado=%h p=%b t=%b r=%b g=%b expected D 1 1 1 0", db_estado, perdeu, db_timeout, pronto, ganhou);
    end
  endtask

  task automatic test_late_press_and_multikey();
    start();
    repeat (99) @(negedge clock);
    vectors++;
    if (db_estado !== 4'h2) begin miscompares++; $display("FAIL before_deadline: got %h expected 2", db_estado); end
    press(4'b0001, 0);
    vectors++;
    if ({db_estado, perdeu, db_rodada} !== {4'h2, 1'b0, 4'h1}) begin
      miscompares++;
      $display("FAIL late_press: got estado=%h p=%b rodada=%h expected 2 0 1", db_estado, perdeu, db_rodada);
    end
    press(4'b0011, 0);
    vectors++;
    if ({db_estado, perdeu} !== {4'hE, 1'b1}) begin miscompares++; $display("FAIL multikey: got estado=%h p=%b expected E 1", db_estado, perdeu); end
  endtask

  task automatic test_held_and_reset_mid();
    int p = 0;
    start();
    sb.push_back({4'b0001, 1'b1});
    chaves = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (db_tem_jogada) p++;
      @(negedge clock);
    end
    chaves = 4'b0;
    @(negedge clock);
    vectors++;
    if (p !== 1) begin miscompares++; $display("FAIL held_pulses: got %0d expected 1", p); end
    vectors++;
    if ({db_estado, db_rodada} !== {4'h2, 4'h1}) begin miscompares++; $display("FAIL held_state: got estado=%h rodada=%h expected 2 1", db_estado, db_rodada); end
    press(4'b0001, 0);
    press(4'b0010, 1);
    press(4'b0001, 0);
    vectors++;
    if ({db_rodada, db_contagem} !== 8'h21) begin miscompares++; $display("FAIL round2_pos: got %h%h expected 21", db_rodada, db_contagem); end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({db_estado, leds, db_rodada, db_contagem, pronto} !== 17'b0) begin
      miscompares++;
      $display("FAIL async_reset: got estado=%h leds=%b rodada=%h contagem=%h r=%b expected all 0", db_estado, leds, db_rodada, db_contagem, pronto);
    end
    vectors++;
    if (sb.size() !== 0) begin miscompares++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    vectors++;
    if (db_estado !== 4'h0) begin miscompares++; $display("FAIL post_reset_idle: got %h expected 0", db_estado); end
  endtask

  initial begin
    test_reset();
    test_win();
    test_error();
    test_timeout();
    test_late_press_and_multikey();
    test_held_and_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
